// File: rtl/rx_frame_if.sv
// rx_frame_if: buffer read port, header fields and payload stream of the frame reader.
interface rx_frame_if #(parameter int RAM_ADDR_BITS = 14);
  logic                     Frm_valid;
  logic                     Rd_en;
  logic [RAM_ADDR_BITS-1:0] Rd_Addr;
  logic [7:0]               Rd_data;
  logic [47:0]              dst_mac;
  logic [47:0]              src_mac;
  logic [15:0]              eth_type;
  logic                     hdr_valid;
  logic [7:0]               m_data;
  logic                     m_valid;
  logic                     m_last;
  logic                     m_ready;
  logic                     frm_done;
  logic                     len_err;
  logic [15:0]              frm_cnt;
  modport master (
    input  Frm_valid, Rd_data, m_ready,
    output Rd_en, Rd_Addr, dst_mac, src_mac, eth_type, hdr_valid,
           m_data, m_valid, m_last, frm_done, len_err, frm_cnt
  );
  modport slave (
    output Frm_valid, Rd_data, m_ready,
    input  Rd_en, Rd_Addr, dst_mac, src_mac, eth_type, hdr_valid,
           m_data, m_valid, m_last, frm_done, len_err, frm_cnt
  );
endinterface

// File: rtl/rx_frame_reader.sv
// rx_frame_reader: reads a stored frame, captures the Ethernet header and streams the payload without FCS.
module rx_frame_reader #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 14,
  parameter int MIN_FRM       = 18
) (
  input logic        GMII_RX_CLK,
  input logic        reset,
  rx_frame_if.master frm_io
);
  typedef enum logic [2:0] {IDLE, RD_LEN, HDR, PAYLOAD, RELEASE} state_t;
  state_t                   st_q;
  logic [RAM_ADDR_BITS-1:0] addr_q;
  logic [7:0]               hi_q;
  logic [15:0]              len_q, len_w, addr_w, frm_cnt_q;
  logic [111:0]             hdr_q;
  logic                     en_q, hv_q, done_q, lerr_q, mv_q;
  logic                     av_q, al_q, dv_q, dl_q, pop, fetch, bad_len;
  logic [RAM_WIDTH-1:0]     buf_q [3];
  logic [RAM_WIDTH-1:0]     buf_d [3];
  logic [2:0]               lst_q, lst_d;
  logic [1:0]               cnt_q, cnt_d;
  assign len_w   = {hi_q, frm_io.Rd_data};
  assign addr_w  = 16'(addr_q);
  assign bad_len = len_w < 16'(MIN_FRM + 1) || len_w > 16'((1 << RAM_ADDR_BITS) - 1);
  assign frm_io.Rd_en     = en_q;
  assign frm_io.Rd_Addr   = addr_q;
  assign frm_io.dst_mac   = hdr_q[111:64];
  assign frm_io.src_mac   = hdr_q[63:16];
  assign frm_io.eth_type  = hdr_q[15:0];
  assign frm_io.hdr_valid = hv_q;
  assign frm_io.m_data    = buf_q[0];
  assign frm_io.m_valid   = mv_q;
  assign frm_io.m_last    = lst_q[0];
  assign frm_io.frm_done  = done_q;
  assign frm_io.len_err   = lerr_q;
  assign frm_io.frm_cnt   = frm_cnt_q;
  // Entry 0 is the output register; av/dv track the read whose address or data is in flight.
  always_comb begin
    pop      = mv_q & frm_io.m_ready;
    buf_d[0] = pop ? buf_q[1] : buf_q[0];
    buf_d[1] = pop ? buf_q[2] : buf_q[1];
    buf_d[2] = buf_q[2];
    lst_d    = pop ? {1'b0, lst_q[2:1]} : lst_q;
    cnt_d    = cnt_q - {1'b0, pop};
    if (dv_q) begin
      buf_d[cnt_d] = frm_io.Rd_data;
      lst_d[cnt_d] = dl_q;
      cnt_d        = cnt_d + 2'd1;
    end
    fetch = (st_q == PAYLOAD || (st_q == HDR && addr_w == 16'd16)) && addr_w < len_q - 16'd4
            && {1'b0, cnt_d} + {2'b0, av_q} <= 3'd2;
  end
  always_ff @(posedge GMII_RX_CLK) begin
    if (reset) begin
      st_q      <= IDLE;
      addr_q    <= '0;
      hi_q      <= '0;
      len_q     <= '0;
      hdr_q     <= '0;
      frm_cnt_q <= '0;
      en_q      <= 1'b0;
      hv_q      <= 1'b0;
      done_q    <= 1'b0;
      lerr_q    <= 1'b0;
      mv_q      <= 1'b0;
      av_q      <= 1'b0;
      al_q      <= 1'b0;
      dv_q      <= 1'b0;
      dl_q      <= 1'b0;
      buf_q     <= '{default: '0};
      lst_q     <= '0;
      cnt_q     <= '0;
    end else begin
      hv_q   <= 1'b0;
      done_q <= 1'b0;
      lerr_q <= 1'b0;
      buf_q  <= buf_d;
      lst_q  <= lst_d;
      cnt_q  <= cnt_d;
      mv_q   <= cnt_d != 2'd0;
      dv_q   <= av_q;
      dl_q   <= al_q;
      av_q   <= fetch;
      al_q   <= fetch && addr_w + 16'd1 == len_q - 16'd4;
      if (fetch) addr_q <= addr_q + 1'b1;
      case (st_q)
        IDLE: if (frm_io.Frm_valid) begin
          en_q   <= 1'b1;
          addr_q <= '0;
          st_q   <= RD_LEN;
        end
        RD_LEN: begin
          if (addr_w == 16'd0) addr_q <= 1;
          else if (addr_w == 16'd1) begin
            hi_q   <= frm_io.Rd_data;
            addr_q <= 2;
          end else begin
            len_q  <= len_w;
            addr_q <= bad_len ? '0 : 3;
            en_q   <= !bad_len;
            lerr_q <= bad_len;
            st_q   <= bad_len ? RELEASE : HDR;
          end
        end
        HDR: begin
          hdr_q <= {hdr_q[103:0], frm_io.Rd_data};
          if (addr_w == 16'd15) begin
            addr_q <= 16;
            av_q   <= len_q >= 16'd20;
            al_q   <= len_q == 16'd20;
          end else if (addr_w == 16'd16) begin
            hv_q <= 1'b1;
            st_q <= len_q == 16'd19 ? RELEASE : PAYLOAD;
            if (len_q == 16'd19) begin
              en_q      <= 1'b0;
              addr_q    <= '0;
              done_q    <= 1'b1;
              frm_cnt_q <= frm_cnt_q + 16'd1;
            end
          end else addr_q <= addr_q + 1'b1;
        end
        PAYLOAD: if (pop && lst_q[0]) begin
          en_q      <= 1'b0;
          addr_q    <= '0;
          done_q    <= 1'b1;
          frm_cnt_q <= frm_cnt_q + 16'd1;
          st_q      <= RELEASE;
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rx_frame_reader.sv
// tb_rx_frame_reader: directed frame scenarios with random contents and m_ready, checked against a frame-level model.
module tb_rx_frame_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  rx_frame_if #(.RAM_ADDR_BITS(14)) bus ();
  rx_frame_reader dut (.GMII_RX_CLK(clk), .reset(reset), .frm_io(bus));
  logic [7:0] mem [16384];
  always @(posedge clk) bus.Rd_data <= mem[bus.Rd_Addr];
  int tests = 0, fails = 0, exp_cnt = 0;
  logic [7:0] fb [2][1600];
  int fn [2];
  int cur_l, hv_n, done_n, lerr_n, mv_n, over, lat;
  logic [8:0] rxq [$];
  logic [8:0] expq [$];
  int gaps [$];
  task automatic chk(input string tag, input logic [111:0] got, input logic [111:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic build(input int s, input int n, input logic [15:0] et);
    fn[s] = n;
    for (int i = 0; i < n; i++) fb[s][i] = 8'($urandom);
    if (n >= 14) begin
      fb[s][12] = et[15:8];
      fb[s][13] = et[7:0];
    end
  endtask
  task automatic load(input int s);
    logic [15:0] l;
    l = 16'(fn[s] + 1);
    cur_l = fn[s] + 1;
    mem[0] = l[15:8];
    mem[1] = l[7:0];
    for (int i = 0; i < fn[s]; i++) mem[2 + i] = fb[s][i];
  endtask
  // Frames are handed over one after another: a new image is loaded as soon as Rd_en releases the buffer.
  task automatic run(input int nfr, input int mode, input int rst_at);
    int cyc = 0, falls = 0, since = 0, lowc = 0, pi = 0;
    logic pen = 1'b0, stall = 1'b0;
    logic [7:0] pdata = '0;
    logic [7:0] pat = 8'b1011_0010;
    logic [111:0] eh;
    rxq.delete(); expq.delete(); gaps.delete();
    hv_n = 0; done_n = 0; lerr_n = 0; mv_n = 0; over = 0; lat = -1;
    for (int f = 0; f < nfr; f++)
      for (int i = 14; i <= fn[f] - 5; i++) expq.push_back({i == fn[f] - 5, fb[f][i]});
    load(0);
    bus.Frm_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (mode == 0) bus.m_ready = 1'b1;
      else if (mode == 1) bus.m_ready = pat[3'(7 - pi % 8)];
      else bus.m_ready = 1'($urandom_range(0, 1));
      pi++;
      if (bus.hdr_valid) begin
        hv_n++;
        for (int i = 0; i < 14; i++) eh = {eh[103:0], fb[falls][i]};
        chk("header", {bus.dst_mac, bus.src_mac, bus.eth_type}, eh);
      end
      if (bus.frm_done) done_n++;
      if (bus.len_err) lerr_n++;
      if (bus.m_valid) begin
        mv_n++;
        if (lat < 0) lat = cyc;
      end
      if (stall) begin
        chk("stall_valid", bus.m_valid, 1);
        chk("stall_data", bus.m_data, pdata);
      end
      stall = bus.m_valid & !bus.m_ready;
      pdata = bus.m_data;
      if (bus.m_valid && bus.m_ready) rxq.push_back({bus.m_last, bus.m_data});
      if (bus.Rd_en && int'(bus.Rd_Addr) > cur_l) over++;
      if (rst_at > 0 && rxq.size() == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rd_en", bus.Rd_en, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_frm_done", bus.frm_done, 0);
        chk("rst_frm_cnt", bus.frm_cnt, 0);
        reset = 1'b0;
        bus.Frm_valid = 1'b0;
        break;
      end
      if (pen && !bus.Rd_en) begin
        falls++;
        lowc = 0;
        if (falls < nfr) load(falls);
        else bus.Frm_valid = 1'b0;
      end
      if (!bus.Rd_en) lowc++;
      if (!pen && bus.Rd_en && falls > 0) gaps.push_back(lowc);
      pen = bus.Rd_en;
      if (falls == nfr) since++;
      if (since > 3) break;
      if (cyc > 20000) begin
        chk("timeout", cyc, 0);
        break;
      end
    end
  endtask
  task automatic check_stream(input string tag, input bit prefix);
    int bad = 0;
    if (!prefix) chk({tag, "_len"}, rxq.size(), expq.size());
    for (int i = 0; i < rxq.size() && i < expq.size(); i++) if (rxq[i] !== expq[i]) bad++;
    chk({tag, "_data"}, bad, 0);
    chk({tag, "_addr_sat"}, over, 0);
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    bus.Frm_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", bus.Rd_en, 0);
    chk("rst_rd_addr", bus.Rd_Addr, 0);
    chk("rst_outs", {bus.m_valid, bus.m_last, bus.m_data, bus.hdr_valid, bus.frm_done, bus.len_err}, 0);
    chk("rst_hdr", {bus.dst_mac, bus.src_mac, bus.eth_type}, 0);
    chk("rst_frm_cnt", bus.frm_cnt, 0);
    reset = 1'b0;
    build(0, 64, 16'hAA55);
    run(1, 0, -1);
    exp_cnt++;
    chk("a_latency", lat, 19);
    chk("a_hdr_valid", hv_n, 1);
    chk("a_beats", mv_n, 46);
    chk("a_done", done_n, 1);
    chk("a_frm_cnt", bus.frm_cnt, exp_cnt);
    check_stream("a", 0);
    run(1, 1, -1);
    exp_cnt++;
    chk("b_done", done_n, 1);
    chk("b_frm_cnt", bus.frm_cnt, exp_cnt);
    check_stream("b", 0);
    build(0, 18, 16'(($urandom)));
    run(1, 2, -1);
    exp_cnt++;
    chk("c_hdr_valid", hv_n, 1);
    chk("c_no_valid", mv_n, 0);
    chk("c_done", done_n, 1);
    chk("c_frm_cnt", bus.frm_cnt, exp_cnt);
    build(0, 10, 16'h0800);
    build(1, 30, 16'h0800);
    run(2, 2, -1);
    exp_cnt++;
    chk("d_len_err", lerr_n, 1);
    chk("d_hdr_valid", hv_n, 1);
    chk("d_done", done_n, 1);
    chk("d_gap", gaps[0], 2);
    chk("d_frm_cnt", bus.frm_cnt, exp_cnt);
    check_stream("d", 0);
    build(0, 40, 16'h1234);
    build(1, 70, 16'h5678);
    run(2, 2, -1);
    exp_cnt += 2;
    chk("e_gap", gaps[0], 2);
    chk("e_hdr_valid", hv_n, 2);
    chk("e_done", done_n, 2);
    chk("e_frm_cnt", bus.frm_cnt, exp_cnt);
    check_stream("e", 0);
    build(0, 1500, 16'h0800);
    run(1, 2, 20);
    exp_cnt = 0;
    chk("f_no_done", done_n, 0);
    chk("f_rx_count", rxq.size(), 20);
    check_stream("f", 1);
    build(0, 100 + int'($urandom_range(0, 60)), 16'h86DD);
    run(1, 2, -1);
    exp_cnt++;
    chk("g_done", done_n, 1);
    chk("g_frm_cnt", bus.frm_cnt, exp_cnt);
    check_stream("g", 0);
    for (int k = 0; k < 3; k++) begin
      build(0, int'($urandom_range(18, 300)), 16'($urandom));
      run(1, int'($urandom_range(0, 2)), -1);
      exp_cnt++;
      chk("h_frm_cnt", bus.frm_cnt, exp_cnt);
      check_stream("h", 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
